vga_timing_gen: RTL

- Free-running XGA 1024x768@60 raster generator on the 65 MHz pixel clock.
- Produces the horizontal/vertical counters, blanking and sync flags that every downstream draw stage consumes: background, start screen, duck sprites, score overlay.
- Adds single-cycle game-update strobes so game logic moves objects only during vertical blanking.
- All timing defaults come from the shared vga package constants.

---
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// XGA 1024x768@60 raster timing generator.
// Produces pixel/line counters plus blanking, sync and game-update strobes.
// Every output is a register, and each one describes the raster position
// shown in that same cycle.

package vga_pkg;
    localparam int unsigned H_TOTAL       = 1344;
    localparam int unsigned H_BLANK_START = 1024;
    localparam int unsigned H_SYNC_START  = 1048;
    localparam int unsigned H_SYNC_END    = 1184;
    localparam int unsigned V_TOTAL       = 806;
    localparam int unsigned V_BLANK_START = 768;
    localparam int unsigned V_SYNC_START  = 771;
    localparam int unsigned V_SYNC_END    = 777;
    localparam int unsigned FRAME_CNT_W   = 16;
endpackage

module vga_timing_gen #(
    parameter int unsigned H_TOTAL       = vga_pkg::H_TOTAL,
    parameter int unsigned H_BLANK_START = vga_pkg::H_BLANK_START,
    parameter int unsigned H_SYNC_START  = vga_pkg::H_SYNC_START,
    parameter int unsigned H_SYNC_END    = vga_pkg::H_SYNC_END,
    parameter int unsigned V_TOTAL       = vga_pkg::V_TOTAL,
    parameter int unsigned V_BLANK_START = vga_pkg::V_BLANK_START,
    parameter int unsigned V_SYNC_START  = vga_pkg::V_SYNC_START,
    parameter int unsigned V_SYNC_END    = vga_pkg::V_SYNC_END,
    parameter int unsigned FRAME_CNT_W   = vga_pkg::FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [10:0]            hcount,
    output logic [10:0]            vcount,
    output logic                   hblnk,
    output logic                   vblnk,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   line_end,
    output logic                   frame_end,
    output logic                   vblank_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned CW = 11;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_BS   = CW'(H_BLANK_START);
    localparam logic [CW-1:0] H_SS   = CW'(H_SYNC_START);
    localparam logic [CW-1:0] H_SE   = CW'(H_SYNC_END);
    localparam logic [CW-1:0] V_BS   = CW'(V_BLANK_START);
    localparam logic [CW-1:0] V_SS   = CW'(V_SYNC_START);
    localparam logic [CW-1:0] V_SE   = CW'(V_SYNC_END);

    logic          h_wrap;
    logic          v_wrap;
    logic          frame_wrap;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;

    logic hblnk_d;
    logic vblnk_d;
    logic hsync_d;
    logic vsync_d;
    logic line_end_d;
    logic frame_end_d;
    logic vblank_start_d;

    // Next raster position: column advances every clock, line on column wrap.
    always_comb begin
        h_wrap     = (hcount == H_LAST);
        v_wrap     = (vcount == V_LAST);
        frame_wrap = h_wrap && v_wrap;
        h_next     = h_wrap ? '0 : hcount + CW'(1);
        v_next     = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vcount + CW'(1);
        end
    end

    // Flags decoded from the next position so they register alongside it.
    always_comb begin
        hblnk_d        = (h_next >= H_BS);
        vblnk_d        = (v_next >= V_BS);
        hsync_d        = (h_next >= H_SS) && (h_next < H_SE);
        vsync_d        = (v_next >= V_SS) && (v_next < V_SE);
        line_end_d     = (h_next == H_LAST);
        frame_end_d    = (h_next == H_LAST) && (v_next == V_LAST);
        vblank_start_d = (h_next == '0) && (v_next == V_BS);
    end

    // Raster counters and aligned flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount       <= '0;
            vcount       <= '0;
            hblnk        <= 1'b0;
            vblnk        <= 1'b0;
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            line_end     <= 1'b0;
            frame_end    <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            hcount       <= h_next;
            vcount       <= v_next;
            hblnk        <= hblnk_d;
            vblnk        <= vblnk_d;
            hsync        <= hsync_d;
            vsync        <= vsync_d;
            line_end     <= line_end_d;
            frame_end    <= frame_end_d;
            vblank_start <= vblank_start_d;
        end
    end

    // Completed-frame count, bumped as the counters wrap to 0,0.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

endmodule
